// File: rtl/key_debounce.sv
// Multi-key debouncer: per-key 2-flop synchroniser, debounce FSM and hold timer.
// Emits a debounced level plus registered one-cycle press/release/long pulses.
module key_debounce #(
    parameter int unsigned KEY_NUM     = 2,
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LONG_CYCLES = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        RELEASE_DEB
    } state_t;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        logic          s1, s2;
        state_t        state, state_nxt;
        logic [DW-1:0] deb_cnt, deb_cnt_nxt;
        logic [HW-1:0] hold_cnt, hold_cnt_nxt;
        logic          long_done, long_done_nxt;
        logic          level_q, level_nxt;
        logic          press_q, press_nxt;
        logic          release_q, release_nxt;
        logic          long_q, long_nxt;

        // Pins are active-low; the synchroniser idles at 1 (released).
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                s1 <= 1'b1;
                s2 <= 1'b1;
            end else begin
                s1 <= key_in[k];
                s2 <= s1;
            end
        end

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state     <= IDLE;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                long_done <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                deb_cnt   <= deb_cnt_nxt;
                hold_cnt  <= hold_cnt_nxt;
                long_done <= long_done_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
            end
        end

        always_comb begin
            state_nxt     = state;
            deb_cnt_nxt   = deb_cnt;
            hold_cnt_nxt  = hold_cnt;
            long_done_nxt = long_done;
            level_nxt     = level_q;
            press_nxt     = 1'b0;
            release_nxt   = 1'b0;
            long_nxt      = 1'b0;
            unique case (state)
                IDLE: begin
                    if (!s2) begin
                        state_nxt   = PRESS_DEB;
                        deb_cnt_nxt = '0;
                    end
                end
                PRESS_DEB: begin
                    if (s2) begin
                        state_nxt = IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt     = HELD;
                        press_nxt     = 1'b1;
                        level_nxt     = 1'b1;
                        hold_cnt_nxt  = '0;
                        long_done_nxt = 1'b0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (s2) begin
                        state_nxt   = RELEASE_DEB;
                        deb_cnt_nxt = '0;
                    end else if (hold_cnt == LONG_LAST) begin
                        // Saturated: fire once, long_done blocks repeats after release bounce.
                        if (!long_done) begin
                            long_nxt      = 1'b1;
                            long_done_nxt = 1'b1;
                        end
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                RELEASE_DEB: begin
                    if (!s2) begin
                        state_nxt = HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                        level_nxt   = 1'b0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_long[k]    = long_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing pins,
// checked every cycle against a run-length reference model.
module tb_key_debounce;

    localparam int KEY_NUM = 2;
    localparam int DEB     = 4;
    localparam int LONG    = 20;

    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic [KEY_NUM-1:0] key_in  = '1;
    logic [KEY_NUM-1:0] key_level, key_press, key_release, key_long;

    int n_cmp = 0;
    int n_err = 0;

    key_debounce #(
        .KEY_NUM    (KEY_NUM),
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sampled pin is the raw pin two edges late. A level change
    // is accepted after DEB+1 consecutive samples disagreeing with the level;
    // long fires on the LONG-th undisturbed held sample after the press.
    bit                 m_s1 [KEY_NUM] = '{default: 1'b1};
    bit                 m_s2 [KEY_NUM] = '{default: 1'b1};
    int                 run  [KEY_NUM] = '{default: 0};
    int                 held [KEY_NUM] = '{default: 0};
    logic [KEY_NUM-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int k = 0; k < KEY_NUM; k++) begin
                m_s1[k] = 1'b1;
                m_s2[k] = 1'b1;
                run[k]  = 0;
                held[k] = 0;
            end
            e_level = '0; e_press = '0; e_release = '0; e_long = '0;
        end else begin
            e_press = '0; e_release = '0; e_long = '0;
            for (int k = 0; k < KEY_NUM; k++) begin
                bit pressed;
                pressed = !m_s2[k];
                if (pressed != e_level[k]) begin
                    run[k]++;
                    if (run[k] == DEB + 1) begin
                        e_level[k] = pressed;
                        run[k]     = 0;
                        if (pressed) begin
                            e_press[k] = 1'b1;
                            held[k]    = 0;
                        end else begin
                            e_release[k] = 1'b1;
                        end
                    end
                end else begin
                    if (e_level[k] && run[k] == 0) begin
                        if (held[k] <= LONG) held[k]++;
                        if (held[k] == LONG) e_long[k] = 1'b1;
                    end
                    run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = key_in[k];
            end
        end
    end

    int cyc = 0;
    int n_press [KEY_NUM] = '{default: 0};
    int n_rel   [KEY_NUM] = '{default: 0};
    int n_long  [KEY_NUM] = '{default: 0};
    int rel_cyc [KEY_NUM] = '{default: 0};
    int prs_cyc [KEY_NUM] = '{default: 0};
    int lng_cyc [KEY_NUM] = '{default: 0};

    always @(negedge sys_clk) begin
        cyc++;
        check_eq("level",   32'(key_level),   32'(e_level));
        check_eq("press",   32'(key_press),   32'(e_press));
        check_eq("release", 32'(key_release), 32'(e_release));
        check_eq("long",    32'(key_long),    32'(e_long));
        for (int k = 0; k < KEY_NUM; k++) begin
            if (key_press[k])   begin n_press[k]++; prs_cyc[k] = cyc; end
            if (key_release[k]) begin n_rel[k]++;   rel_cyc[k] = cyc; end
            if (key_long[k])    begin n_long[k]++;  lng_cyc[k] = cyc; end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #2;
        end
    endtask

    int bp, br, bl;
    int rem [KEY_NUM];

    initial begin
        step(3);
        sys_rst = 1'b0;
        step(5);
        check_eq("reset_level", 32'(key_level), 32'd0);

        // Clean press and release on key 0
        key_in[0] = 1'b0;
        step(6);
        check_eq("press_early", 32'(key_press[0]), 32'd0);
        step(1);
        check_eq("press_lat", 32'(key_press[0]), 32'd1);
        check_eq("press_lvl", 32'(key_level[0]), 32'd1);
        step(3);
        key_in[0] = 1'b1;
        step(6);
        check_eq("rel_early", 32'(key_release[0]), 32'd0);
        step(1);
        check_eq("rel_lat", 32'(key_release[0]), 32'd1);
        check_eq("rel_lvl", 32'(key_level[0]), 32'd0);
        check_eq("short_nolong", 32'(n_long[0]), 32'd0);
        step(10);

        // Bounce rejection
        bp = n_press[0];
        for (int i = 0; i < 10; i++) begin
            key_in[0] = 1'(i % 2);
            step(2);
        end
        key_in[0] = 1'b1;
        step(10);
        check_eq("bounce_press", 32'(n_press[0] - bp), 32'd0);
        check_eq("bounce_lvl", 32'(key_level[0]), 32'd0);

        // Long press on key 1
        bp = n_press[1]; br = n_rel[1]; bl = n_long[1];
        key_in[1] = 1'b0;
        step(40);
        key_in[1] = 1'b1;
        step(15);
        check_eq("long_press_n", 32'(n_press[1] - bp), 32'd1);
        check_eq("long_n", 32'(n_long[1] - bl), 32'd1);
        check_eq("long_rel_n", 32'(n_rel[1] - br), 32'd1);
        check_eq("long_lat", 32'(lng_cyc[1] - prs_cyc[1]), 32'(LONG));

        // Release bounce after long press on key 0
        br = n_rel[0]; bl = n_long[0];
        key_in[0] = 1'b0;
        step(35);
        key_in[0] = 1'b1;
        step(2);
        key_in[0] = 1'b0;
        step(15);
        check_eq("rb_rel", 32'(n_rel[0] - br), 32'd0);
        check_eq("rb_long", 32'(n_long[0] - bl), 32'd1);
        check_eq("rb_lvl", 32'(key_level[0]), 32'd1);
        key_in[0] = 1'b1;
        step(15);
        check_eq("rb_rel2", 32'(n_rel[0] - br), 32'd1);
        check_eq("rb_long2", 32'(n_long[0] - bl), 32'd1);

        // Simultaneous keys
        key_in = '0;
        step(7);
        check_eq("sim_press", 32'(key_press), 32'd3);
        step(5);
        key_in[0] = 1'b1;
        step(3);
        key_in[1] = 1'b1;
        step(15);
        check_eq("sim_rel_gap", 32'(rel_cyc[1] - rel_cyc[0]), 32'd3);

        // Reset mid-press
        key_in[0] = 1'b0;
        step(12);
        check_eq("mid_lvl", 32'(key_level[0]), 32'd1);
        sys_rst = 1'b1;
        #1;
        check_eq("rst_outs", 32'({key_level, key_press, key_release, key_long}), 32'd0);
        step(2);
        sys_rst = 1'b0;
        step(6);
        check_eq("rst_press_early", 32'(key_press[0]), 32'd0);
        step(1);
        check_eq("rst_repress", 32'(key_press[0]), 32'd1);
        key_in[0] = 1'b1;
        step(15);

        // Random bouncing pins with occasional reset pulses
        for (int k = 0; k < KEY_NUM; k++) rem[k] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < KEY_NUM; k++) begin
                if (rem[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    rem[k] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 7))
                                                        : int'($urandom_range(6, 45));
                end
                rem[k]--;
            end
            sys_rst = ($urandom_range(0, 999) == 0);
            step(1);
        end
        sys_rst = 1'b0;
        key_in  = '1;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
